// File: rtl/shift_add_multiplier_n_pkg.sv
// Shared definitions for the shift-add multiplier: FSM encoding and the
// conditional two's-complement negate used for sign-magnitude handling.
package shift_add_mult_pkg;

    localparam int ST_W  = 3;
    localparam int MAX_W = 64;

    typedef enum logic [ST_W-1:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        TEST  = 3'd2,
        ADD   = 3'd3,
        SHIFT = 3'd4,
        FIX   = 3'd5
    } state_t;

    // Caller zero-extends to 64 bits and truncates the result back to its own
    // width, which yields negation mod 2^width for any width up to 64.
    function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] v,
                                                  input logic             neg);
        cond_neg = neg ? (~v + 64'd1) : v;
    endfunction

endpackage

// File: rtl/shift_add_multiplier_n_if.sv
// Start/done handshake bundle between a bus-side wrapper (master) and the
// multiplier (slave).
interface shift_add_multiplier_n_if #(
    parameter int WIDTH = 8
);
    logic               i_START;
    logic               i_SIGNED;
    logic [WIDTH-1:0]   i_MULTIPLICAND;
    logic [WIDTH-1:0]   i_MULTIPLIER;
    logic               o_BUSY;
    logic               o_DONE;
    logic [2*WIDTH-1:0] o_PRODUCT;

    modport master (
        output i_START, i_SIGNED, i_MULTIPLICAND, i_MULTIPLIER,
        input  o_BUSY, o_DONE, o_PRODUCT
    );

    modport slave (
        input  i_START, i_SIGNED, i_MULTIPLICAND, i_MULTIPLIER,
        output o_BUSY, o_DONE, o_PRODUCT
    );
endinterface

// File: rtl/shift_add_multiplier_n_datapath.sv
// M/A/C/Q register file of the shift-add multiplier plus the product register;
// every register moves only on a one-hot command from the controller.
module shift_add_datapath
    import shift_add_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               i_CLK,
    input  logic               i_RESET,
    input  logic               i_load,
    input  logic               i_init,
    input  logic               i_add,
    input  logic               i_shift,
    input  logic               i_fix,
    input  logic               i_signed,
    input  logic               i_neg,
    input  logic [WIDTH-1:0]   i_m,
    input  logic [WIDTH-1:0]   i_q,
    output logic               o_lsb,
    output logic               o_m_msb,
    output logic               o_q_msb,
    output logic [2*WIDTH-1:0] o_product
);

    logic [WIDTH-1:0]   r_m;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_q;
    logic               r_c;
    logic [2*WIDTH-1:0] r_product;

    logic [WIDTH-1:0]   w_m_abs;
    logic [WIDTH-1:0]   w_q_abs;
    logic [2*WIDTH-1:0] w_fix;

    // |-2^(WIDTH-1)| = 2^(WIDTH-1) still fits WIDTH bits when read as unsigned.
    assign w_m_abs = WIDTH'(cond_neg(64'(r_m), i_signed & r_m[WIDTH-1]));
    assign w_q_abs = WIDTH'(cond_neg(64'(r_q), i_signed & r_q[WIDTH-1]));
    assign w_fix   = (2*WIDTH)'(cond_neg(64'({r_a, r_q}), i_neg));

    always_ff @(posedge i_CLK or negedge i_RESET) begin
        if (!i_RESET) begin
            r_m       <= '0;
            r_a       <= '0;
            r_q       <= '0;
            r_c       <= 1'b0;
            r_product <= '0;
        end else begin
            if (i_load) begin
                r_m <= i_m;
                r_q <= i_q;
            end
            if (i_init) begin
                r_m <= w_m_abs;
                r_q <= w_q_abs;
                r_a <= '0;
                r_c <= 1'b0;
            end
            if (i_add)
                {r_c, r_a} <= {1'b0, r_a} + {1'b0, r_m};
            if (i_shift)
                {r_c, r_a, r_q} <= {1'b0, r_c, r_a, r_q[WIDTH-1:1]};
            if (i_fix)
                r_product <= w_fix;
        end
    end

    assign o_lsb     = r_q[0];
    assign o_m_msb   = r_m[WIDTH-1];
    assign o_q_msb   = r_q[WIDTH-1];
    assign o_product = r_product;

endmodule

// File: rtl/shift_add_multiplier_n.sv
// Sequential shift-add multiplier (signed via sign-magnitude): FSM, iteration
// counter, sign flag and done pulse; the registers live in shift_add_datapath.
module shift_add_multiplier_n
    import shift_add_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                     i_CLK,
    input  logic                     i_RESET,
    shift_add_multiplier_n_if.slave  bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_signed;
    logic             r_neg;
    logic             r_done;

    logic w_load, w_init, w_add, w_shift, w_fix;
    logic w_lsb, w_m_msb, w_q_msb, w_last;

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        w_next  = r_state;
        w_load  = 1'b0;
        w_init  = 1'b0;
        w_add   = 1'b0;
        w_shift = 1'b0;
        w_fix   = 1'b0;
        case (r_state)
            IDLE: if (bus.i_START) begin
                w_load = 1'b1;
                w_next = INIT;
            end
            INIT: begin
                w_init = 1'b1;
                w_next = TEST;
            end
            TEST: w_next = w_lsb ? ADD : SHIFT;
            ADD: begin
                w_add  = 1'b1;
                w_next = SHIFT;
            end
            SHIFT: begin
                w_shift = 1'b1;
                w_next  = w_last ? FIX : TEST;
            end
            FIX: begin
                w_fix  = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_CLK or negedge i_RESET) begin
        if (!i_RESET) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_signed <= 1'b0;
            r_neg    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_fix;
            if (w_load)
                r_signed <= bus.i_SIGNED;
            // Sign comes from the raw operands still held before INIT rewrites them.
            if (w_init) begin
                r_cnt <= '0;
                r_neg <= r_signed & (w_m_msb ^ w_q_msb);
            end
            if (w_shift && !w_last)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    shift_add_datapath #(.WIDTH(WIDTH)) u_dp (
        .i_CLK     (i_CLK),
        .i_RESET   (i_RESET),
        .i_load    (w_load),
        .i_init    (w_init),
        .i_add     (w_add),
        .i_shift   (w_shift),
        .i_fix     (w_fix),
        .i_signed  (r_signed),
        .i_neg     (r_neg),
        .i_m       (bus.i_MULTIPLICAND),
        .i_q       (bus.i_MULTIPLIER),
        .o_lsb     (w_lsb),
        .o_m_msb   (w_m_msb),
        .o_q_msb   (w_q_msb),
        .o_product (bus.o_PRODUCT)
    );

    assign bus.o_BUSY = (r_state != IDLE);
    assign bus.o_DONE = r_done;

endmodule

// File: tb/tb_shift_add_multiplier_n.sv
// Bench for shift_add_multiplier_n at WIDTH=4 and WIDTH=8: vector table,
// random ops against a product/latency model, and handshake corner sequences.
module tb_shift_add_multiplier_n;
    import shift_add_mult_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shift_add_multiplier_n_if #(.WIDTH(4)) if4 ();
    shift_add_multiplier_n_if #(.WIDTH(8)) if8 ();

    shift_add_multiplier_n #(.WIDTH(4)) dut4 (.i_CLK(clk), .i_RESET(rst_n), .bus(if4.slave));
    shift_add_multiplier_n #(.WIDTH(8)) dut8 (.i_CLK(clk), .i_RESET(rst_n), .bus(if8.slave));

    typedef struct {
        bit          w8;
        bit          sgn;
        logic [7:0]  m;
        logic [7:0]  q;
        logic [15:0] exp;
        int          lat;
    } vec_t;

    typedef struct {
        logic [15:0] prod;
        int          lat;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[11];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input bit w8, input bit st, input bit sgn,
                          input logic [7:0] m, input logic [7:0] q);
        if (w8) begin
            if8.i_START = st; if8.i_SIGNED = sgn;
            if8.i_MULTIPLICAND = m; if8.i_MULTIPLIER = q;
        end else begin
            if4.i_START = st; if4.i_SIGNED = sgn;
            if4.i_MULTIPLICAND = m[3:0]; if4.i_MULTIPLIER = q[3:0];
        end
    endtask

    function automatic logic get_done(input bit w8);
        return w8 ? if8.o_DONE : if4.o_DONE;
    endfunction

    function automatic logic get_busy(input bit w8);
        return w8 ? if8.o_BUSY : if4.o_BUSY;
    endfunction

    function automatic logic [15:0] get_prod(input bit w8);
        return w8 ? if8.o_PRODUCT : {8'h00, if4.o_PRODUCT};
    endfunction

    function automatic int to_int(input bit w8, input bit sgn, input logic [7:0] v);
        int w = w8 ? 8 : 4;
        int r = w8 ? int'(v) : int'(v[3:0]);
        if (sgn && v[w-1]) r -= (1 << w);
        return r;
    endfunction

    function automatic logic [15:0] model_prod(input bit w8, input bit sgn,
                                               input logic [7:0] m, input logic [7:0] q);
        int p = to_int(w8, sgn, m) * to_int(w8, sgn, q);
        return w8 ? 16'(p) : {8'h00, 8'(p)};
    endfunction

    function automatic int model_lat(input bit w8, input bit sgn, input logic [7:0] q);
        int b = to_int(w8, sgn, q);
        if (b < 0) b = -b;
        return 3 + 2 * (w8 ? 8 : 4) + $countones(b);
    endfunction

    // Call just before the posedge that should accept the start.
    task automatic start_op(input bit w8, input bit sgn, input logic [7:0] m,
                            input logic [7:0] q, input logic [15:0] exp, input int lat);
        exp_t e;
        set_in(w8, 1'b1, sgn, m, q);
        e.prod = exp;
        e.lat  = lat;
        sb.push_back(e);
    endtask

    // Edge 1 is the next posedge. Optionally re-assert START with other
    // operands over edges [inj_lo, inj_hi) to show it is ignored while busy.
    task automatic wait_done(input bit w8, input string name, input bit hold_chk,
                             input logic [15:0] hold_val, input int inj_lo, input int inj_hi);
        exp_t e;
        int   n = 0;
        bit   busy_bad = 0;
        bit   hold_bad = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 1)      set_in(w8, 1'b0, 1'b0, 8'h00, 8'h00);
            if (n == inj_lo) set_in(w8, 1'b1, 1'b1, 8'h81, 8'h7E);
            if (n == inj_hi) set_in(w8, 1'b0, 1'b0, 8'h00, 8'h00);
            if (!get_done(w8)) begin
                if (!get_busy(w8)) busy_bad = 1;
                if (hold_chk && get_prod(w8) !== hold_val) hold_bad = 1;
            end
        end while (!get_done(w8) && n < 200);
        check({name, "_done"}, 32'(get_done(w8)), 32'd1);
        if (sb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL %s_sb: got empty queue expected one entry", name);
        end else begin
            e = sb.pop_front();
            check({name, "_lat"}, 32'(n), 32'(e.lat));
            check({name, "_prod"}, 32'(get_prod(w8)), 32'(e.prod));
        end
        check({name, "_idle_at_done"}, 32'(get_busy(w8)), 32'd0);
        check({name, "_busy_while_run"}, 32'(busy_bad), 32'd0);
        if (hold_chk) check({name, "_prod_hold"}, 32'(hold_bad), 32'd0);
    endtask

    task automatic do_op(input vec_t v, input string name);
        @(negedge clk);
        start_op(v.w8, v.sgn, v.m, v.q, v.exp, v.lat);
        wait_done(v.w8, name, 1'b0, 16'h0, 0, 0);
    endtask

    initial begin
        vec_t v;
        int   cnt;

        //          w8  sgn  m      q      exp       lat
        tbl[0]  = '{1'b0, 1'b0, 8'h05, 8'h03, 16'h000F, 13};
        tbl[1]  = '{1'b0, 1'b1, 8'h0D, 8'h05, 16'h00F1, 13};
        tbl[2]  = '{1'b0, 1'b1, 8'h08, 8'h08, 16'h0040, 12};
        tbl[3]  = '{1'b0, 1'b1, 8'h07, 8'h08, 16'h00C8, 12};
        tbl[4]  = '{1'b1, 1'b0, 8'h00, 8'h00, 16'h0000, 19};
        tbl[5]  = '{1'b1, 1'b0, 8'hFF, 8'hFF, 16'hFE01, 27};
        tbl[6]  = '{1'b0, 1'b0, 8'h0F, 8'h0F, 16'h00E1, 15};
        tbl[7]  = '{1'b1, 1'b1, 8'h80, 8'h80, 16'h4000, 20};
        tbl[8]  = '{1'b1, 1'b1, 8'hFF, 8'h01, 16'hFFFF, 20};
        tbl[9]  = '{1'b1, 1'b1, 8'h7F, 8'h81, 16'hC0FF, 26};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 8'h0F, 16'h0000, 15};

        set_in(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_in(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (2) @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            check($sformatf("rst_busy_w%0d", w), 32'(get_busy(w[0])), 32'd0);
            check($sformatf("rst_done_w%0d", w), 32'(get_done(w[0])), 32'd0);
            check($sformatf("rst_prod_w%0d", w), 32'(get_prod(w[0])), 32'd0);
        end
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++)
            do_op(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 24; i++) begin
            v.w8  = i[0];
            v.sgn = 1'($urandom);
            v.m   = 8'($urandom);
            v.q   = 8'($urandom);
            v.exp = model_prod(v.w8, v.sgn, v.m, v.q);
            v.lat = model_lat(v.w8, v.sgn, v.q);
            do_op(v, $sformatf("rnd%0d", i));
        end

        // START re-asserted mid-operation with other operands is ignored.
        @(negedge clk);
        start_op(1'b1, 1'b0, 8'd200, 8'd100, 16'h4E20, 22);
        wait_done(1'b1, "midop", 1'b0, 16'h0, 5, 9);
        cnt = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (get_done(1'b1)) cnt++;
        end
        check("midop_no_second_done", 32'(cnt), 32'd0);
        check("midop_prod_kept", 32'(get_prod(1'b1)), 32'h4E20);

        // Back-to-back: START accepted in the DONE cycle, first result held.
        @(negedge clk);
        start_op(1'b0, 1'b0, 8'h09, 8'h06, 16'h0036, 13);
        wait_done(1'b0, "b2b_a", 1'b0, 16'h0, 0, 0);
        start_op(1'b0, 1'b1, 8'h0B, 8'h03, 16'h00F1, 13);
        wait_done(1'b0, "b2b_b", 1'b1, 16'h0036, 0, 0);

        // Asynchronous reset while in ADD discards the operation.
        @(negedge clk);
        set_in(1'b1, 1'b1, 1'b0, 8'd3, 8'd1);
        @(posedge clk); #1;
        set_in(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        check("rst_mid_in_add", 32'(dut8.r_state), 32'(ADD));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_state", 32'(dut8.r_state), 32'(IDLE));
        check("rst_mid_busy", 32'(get_busy(1'b1)), 32'd0);
        check("rst_mid_done", 32'(get_done(1'b1)), 32'd0);
        check("rst_mid_prod", 32'(get_prod(1'b1)), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(tbl[5], "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
